// File: rtl/mips_mem_stage_if.sv
// -----------------------------------------------------------------------------
// mips_mem_stage_if
// Data-memory request/ready bus between the MEM stage and the data memory.
//   dmem_req    stage -> mem   request valid
//   dmem_we     stage -> mem   1 = write, 0 = read
//   dmem_addr   stage -> mem   byte address, held until the next request
//   dmem_wdata  stage -> mem   store data, held until the next request
//   dmem_ready  mem -> stage   memory completes the request this cycle
//   dmem_rdata  mem -> stage   read data, valid with dmem_req & dmem_ready & !dmem_we
// Modports: master = MEM stage, slave = data memory.
// -----------------------------------------------------------------------------
interface mips_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mips_mem_stage.sv
// -----------------------------------------------------------------------------
// mips_mem_stage
// MEM stage plus MEM/WB pipeline register of a 5-stage MIPS pipeline. Loads and
// stores are run against a variable-latency data memory over a req/ready bus;
// the upstream pipeline is frozen (StallMEM) while an access is outstanding.
//
// Parameters: TIMEOUT  REQ cycles waited for dmem_ready before aborting (>=1)
//             CNT_W    timeout counter width, 2**CNT_W > TIMEOUT
// Ports:
//   CLK, RST_N              clock (rising edge), async active-low reset
//   MemReadMEM/MemwriteMEM  load / store in MEM (both set = store)
//   MemtoregMEM,RegWriteMEM WB control from EX/MEM
//   ALUResultMEM            address / ALU result
//   ReadData2MEM            store data
//   WriteRegMEM             destination register
//   dmem (master)           data-memory bus, see mips_mem_stage_if
//   StallMEM                freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   MemErrMEM               sticky access-timeout flag
//   MisalignMEM             sticky misaligned-access flag (MEM_ALIGN_CHECK_EN only)
//   *WB                     MEM/WB register outputs
// Build option: define MEM_ALIGN_CHECK_EN to reject accesses whose
// ALUResultMEM[1:0] != 0 without issuing a memory request.
// -----------------------------------------------------------------------------
module mips_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   MemReadMEM,
  input  logic                   MemwriteMEM,
  input  logic                   MemtoregMEM,
  input  logic                   RegWriteMEM,
  input  logic [31:0]            ALUResultMEM,
  input  logic [31:0]            ReadData2MEM,
  input  logic [4:0]             WriteRegMEM,
  mips_mem_stage_if.master       dmem,
  output logic                   StallMEM,
  output logic                   MemErrMEM,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                   MisalignMEM,
`endif
  output logic                   MemtoregWB,
  output logic                   RegWriteWB,
  output logic [31:0]            ALUResultWB,
  output logic [31:0]            ReadDataWB,
  output logic [4:0]             WriteRegWB
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               abortR;     // access ended without a valid result
  logic [31:0]        holdData;   // load data captured on ready, presented in DONE
  logic               reqR;
  logic               weR;
  logic [31:0]        addrR;
  logic [31:0]        wdataR;
  logic               memop;

  assign memop = MemReadMEM | MemwriteMEM;

  // Stall is combinational so the op is frozen in EX/MEM on the very edge it is detected.
  assign StallMEM = ((state == IDLE) && memop) || (state == REQ);

  assign dmem.dmem_req   = reqR;
  assign dmem.dmem_we    = weR;
  assign dmem.dmem_addr  = addrR;
  assign dmem.dmem_wdata = wdataR;

  // Access FSM, data-memory request registers and MEM/WB pipeline register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      abortR      <= 1'b0;
      holdData    <= 32'h0;
      reqR        <= 1'b0;
      weR         <= 1'b0;
      addrR       <= 32'h0;
      wdataR      <= 32'h0;
      MemErrMEM   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      MisalignMEM <= 1'b0;
`endif
      MemtoregWB  <= 1'b0;
      RegWriteWB  <= 1'b0;
      ALUResultWB <= 32'h0;
      ReadDataWB  <= 32'h0;
      WriteRegWB  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            // Bubble into WB while the access is in flight.
            MemtoregWB  <= 1'b0;
            RegWriteWB  <= 1'b0;
            ALUResultWB <= 32'h0;
            ReadDataWB  <= 32'h0;
            WriteRegWB  <= 5'd0;
            holdData    <= 32'h0;
            cnt         <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            if (ALUResultMEM[1:0] != 2'b00) begin
              MisalignMEM <= 1'b1;
              abortR      <= 1'b1;
              state       <= DONE;
            end else begin
              reqR   <= 1'b1;
              weR    <= MemwriteMEM;
              addrR  <= ALUResultMEM;
              wdataR <= ReadData2MEM;
              abortR <= 1'b0;
              state  <= REQ;
            end
`else
            reqR   <= 1'b1;
            weR    <= MemwriteMEM;   // read+write together is a store
            addrR  <= ALUResultMEM;
            wdataR <= ReadData2MEM;
            abortR <= 1'b0;
            state  <= REQ;
`endif
          end else begin
            MemtoregWB  <= MemtoregMEM;
            RegWriteWB  <= RegWriteMEM;
            ALUResultWB <= ALUResultMEM;
            ReadDataWB  <= 32'h0;
            WriteRegWB  <= WriteRegMEM;
          end
        end

        REQ: begin
          MemtoregWB  <= 1'b0;
          RegWriteWB  <= 1'b0;
          ALUResultWB <= 32'h0;
          ReadDataWB  <= 32'h0;
          WriteRegWB  <= 5'd0;
          if (dmem.dmem_ready) begin
            reqR  <= 1'b0;
            if (!weR) begin
              holdData <= dmem.dmem_rdata;
            end else begin
              holdData <= 32'h0;
            end
            state <= DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            MemErrMEM <= 1'b1;
            reqR      <= 1'b0;
            abortR    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          // EX/MEM still holds the op (stall was high), so retire it now.
          MemtoregWB  <= MemtoregMEM;
          RegWriteWB  <= RegWriteMEM & ~abortR;
          ALUResultWB <= ALUResultMEM;
          ReadDataWB  <= holdData;
          WriteRegWB  <= WriteRegMEM;
          abortR      <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          reqR  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
